// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Word-wide data-memory responder with programmable wait states.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        read_q;
    logic        write_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          w_req;
    logic          w_go;
    logic          w_in_idle;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic          w_read;
    logic          w_write;
    logic          w_err;
    logic          w_we;
    logic [AW-1:0] w_idx;

    // With zero wait states the access happens on the sampling edge itself,
    // so the live inputs stand in for the not-yet-latched request.
    always_comb begin
        w_in_idle = (state_q == ST_IDLE);
        w_req     = mem_read || mem_write;
        w_go      = (w_in_idle && w_req && (WAIT_CYCLES == 0)) ||
                    ((state_q == ST_WAIT) && (cnt_q == 4'd0));
        w_addr    = w_in_idle ? mem_addr  : addr_q;
        w_wdata   = w_in_idle ? mem_wdata : wdata_q;
        w_be      = w_in_idle ? mem_be    : be_q;
        w_read    = w_in_idle ? mem_read  : read_q;
        w_write   = w_in_idle ? mem_write : write_q;
        w_idx     = w_addr[AW+1:2];
        w_err     = (w_addr[1:0] != 2'b00) || (|w_addr[31:AW+2]) || (w_read && w_write);
        w_we      = w_go && w_write && !w_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        be_q    <= mem_be;
                        read_q  <= mem_read;
                        write_q <= mem_write;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            if (w_go) begin
                ready_q <= 1'b1;
                if (w_err) begin
                    err_q   <= 1'b1;
                    rdata_q <= 32'd0;
                end else begin
                    err_q <= 1'b0;
                    if (!w_write) begin
                        rdata_q <= mem_q[w_idx];
                    end
                end
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we && w_be[i]) begin
                mem_q[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign mem_err   = err_q;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined core's load/store port. It accepts one word-sized read or write request at a time from the core's memory stage and inserts a programmable number of wait states. It returns a one-cycle `mem_ready` completion pulse, which the core's hazard logic uses to stall the pipeline. It sits outside the core, at the far end of the `mem_write`/`mem_addr`/`mem_wdata`/`mem_rdata` interface.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..65536
- WAIT_CYCLES, 1, wait states inserted before each response; 0..15

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- mem_read  in  1  read request
- mem_write  in  1  write request
- mem_addr  in  32  byte address; bits [1:0] must be 0
- mem_wdata  in  32  write data
- mem_be  in  4  byte enables for writes; bit i enables byte lane [8i+7:8i]
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data; valid while mem_ready=1, held afterwards
- mem_err  out  1  error flag qualified by mem_ready

## Operation
- Storage is a DEPTH_WORDS x 32 array. It is not cleared by reset.
- Word index is mem_addr[log2(DEPTH_WORDS)+1:2].
- FSM states are IDLE, WAIT and RESP.
- IDLE, with mem_read or mem_write sampled high:
  - latch addr, wdata, be, read and write;
  - go to RESP if WAIT_CYCLES=0;
  - otherwise go to WAIT with cnt=WAIT_CYCLES-1.
- WAIT: if cnt=0, go to RESP; otherwise decrement cnt. Input changes during WAIT are ignored; latched values are used.
- Leaving for RESP, the access is performed on the latched request:
  - Error if addr[1:0]≠0, or addr[31:2] ≥ DEPTH_WORDS, or read and write were both set.
  - Error: no array write; mem_rdata=0; mem_err=1.
  - Write: update only the enabled byte lanes; mem_rdata unchanged; mem_err=0.
  - Read: mem_rdata = array[index]; mem_err=0.
  - mem_be=0 on a write is legal: no lanes change, response is normal.
- RESP: mem_ready=1 for exactly this cycle, then go to IDLE unconditionally.
- The initiator must hold its request until it sees mem_ready, and must present the next request (or idle) in the following cycle. A request still high in the cycle after RESP is treated as a new request.
- A read to a word written by the previous request returns the new data, because the write lands at the RESP edge.

## Timing
- Reset values: mem_ready=0, mem_err=0, mem_rdata=0, state=IDLE, cnt=0.
- Reset asserted mid-transaction (WAIT or RESP): the transaction is abandoned.
  - A pending write is not performed.
  - No mem_ready is issued after reset release.
- All outputs are registered. There is no combinational input-to-output path.
- Latency: a request first sampled in IDLE in cycle N gets mem_ready high in cycle N+1+WAIT_CYCLES.
- Throughput: one request per WAIT_CYCLES+2 cycles, since one IDLE cycle follows each RESP.
- cnt is 4 bits. It never wraps, because it is loaded at most with 14 and counts down to 0.
- Both request lines low in IDLE: the FSM stays in IDLE and all outputs hold except mem_ready, which stays 0.

## Test plan
- Reset then idle: rst_n low for 3 cycles, then released with no requests for 10 cycles -> mem_ready, mem_err and mem_rdata are 0 throughout.
- Write then read, WAIT_CYCLES=1:
  - write addr 0x10, data 0xDEADBEEF, be=4'hF in cycle 5 -> mem_ready high in cycle 7 only;
  - read addr 0x10 in cycle 8 -> mem_ready in cycle 10 with mem_rdata=0xDEADBEEF and mem_err=0.
- Byte enables: word 0x20 holds 0x11223344; write 0xAABBCCDD with be=4'b0101 -> a later read returns 0x11BB33DD.
- Errors:
  - read at 0x13 -> mem_err=1, mem_rdata=0;
  - write at DEPTH_WORDS*4 -> mem_err=1, and a later read of word 0 is unchanged;
  - mem_read and mem_write both high -> mem_err=1, no array write.
- Latency sweep with WAIT_CYCLES of 0, 3 and 15 -> mem_ready arrives exactly 1, 4 and 16 cycles after the request. The request is held and inputs are toggled during WAIT; the response reflects the latched values.
- Reset mid-write: write 0xCAFEF00D to 0x40 with WAIT_CYCLES=3, and assert rst_n low in the second WAIT cycle.
  - No mem_ready is seen after release.
  - A read of 0x40 returns its pre-write contents.
